// File: rtl/dump_pkg.sv
// Shared types and constants for the CPU architectural-state dumper.
package dump_pkg;

    // Frame walker states: header words, register file, data memory.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_REGS = 2'd2,
        ST_MEM  = 2'd3
    } dump_state_e;

    localparam int HDR_WORDS = 4;

    // Position of each header field within the first HDR_WORDS stream words.
    localparam logic [1:0] HDR_CYCLE = 2'd0;
    localparam logic [1:0] HDR_PC    = 2'd1;
    localparam logic [1:0] HDR_STALL = 2'd2;
    localparam logic [1:0] HDR_FLUSH = 2'd3;

    // Total words in one dump frame.
    function automatic int frame_len(input int num_regs, input int num_mem_words);
        return HDR_WORDS + num_regs + num_mem_words;
    endfunction

endpackage

// File: rtl/event_counter.sv
// Free-running wrap-around event counter with enable and synchronous clear.
module event_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: increment on enable, wrapping naturally at 2^W.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpu_state_dumper.sv
// Streams a fixed-order frame (cycle, PC, stall, flush, regs, memory words)
// of the CPU architectural state over a valid/ready interface.
module cpu_state_dumper
    import dump_pkg::*;
#(
    parameter int NUM_REGS      = 32,
    parameter int NUM_MEM_WORDS = 8,
    parameter int DATA_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [31:0]       pc_i,
    input  logic              trigger_i,
    output logic [4:0]        reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [31:0]       mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_sof_o,
    output logic              out_eof_o,
    output logic              busy_o
);

    localparam int MAX_IDX = (NUM_REGS > NUM_MEM_WORDS) ? NUM_REGS : NUM_MEM_WORDS;
    localparam int IDX_W   = $clog2(MAX_IDX + 1);

    localparam logic [IDX_W-1:0] LAST_HDR = IDX_W'(HDR_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(NUM_MEM_WORDS - 1);
    // Index value meaning "all memory words loaded, last word awaiting handshake".
    localparam logic [IDX_W-1:0] MEM_DONE = IDX_W'(NUM_MEM_WORDS);

    logic [31:0] cycle_cnt_s, stall_cnt_s, flush_cnt_s;

    dump_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_sof_q, out_sof_d;
    logic              out_eof_q, out_eof_d;
    logic [31:0]       shadow_cycle_q, shadow_cycle_d;
    logic [31:0]       shadow_pc_q, shadow_pc_d;
    logic [31:0]       shadow_stall_q, shadow_stall_d;
    logic [31:0]       shadow_flush_q, shadow_flush_d;
    logic [DATA_W-1:0] hdr_word_s;
    logic              load_s;

    event_counter #(.W(32)) u_cycle_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(start_i), .count_o(cycle_cnt_s)
    );
    event_counter #(.W(32)) u_stall_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(start_i & stall_i), .count_o(stall_cnt_s)
    );
    event_counter #(.W(32)) u_flush_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(start_i & flush_i), .count_o(flush_cnt_s)
    );

    // Output register may take a new word when empty or being consumed.
    assign load_s = !out_valid_q || out_ready_i;

    // Read ports follow the load index only while their section is being walked.
    assign reg_addr_o = (state_q == ST_REGS) ? 5'(idx_q) : 5'd0;
    assign mem_addr_o = (state_q == ST_MEM && idx_q != MEM_DONE) ? 32'({idx_q, 2'b00}) : 32'd0;

    // Select the latched header field addressed by the load index.
    always_comb begin
        hdr_word_s = DATA_W'(shadow_cycle_q);
        case (idx_q[1:0])
            HDR_PC:    hdr_word_s = DATA_W'(shadow_pc_q);
            HDR_STALL: hdr_word_s = DATA_W'(shadow_stall_q);
            HDR_FLUSH: hdr_word_s = DATA_W'(shadow_flush_q);
            default:   hdr_word_s = DATA_W'(shadow_cycle_q);
        endcase
    end

    // Frame walker: next state, load index, output register and header shadows.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_sof_d      = out_sof_q;
        out_eof_d      = out_eof_q;
        shadow_cycle_d = shadow_cycle_q;
        shadow_pc_d    = shadow_pc_q;
        shadow_stall_d = shadow_stall_q;
        shadow_flush_d = shadow_flush_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger_i) begin
                    // Word 0 is the live cycle count, identical to what the shadow captures.
                    shadow_cycle_d = cycle_cnt_s;
                    shadow_pc_d    = pc_i;
                    shadow_stall_d = stall_cnt_s;
                    shadow_flush_d = flush_cnt_s;
                    out_valid_d    = 1'b1;
                    out_data_d     = DATA_W'(cycle_cnt_s);
                    out_sof_d      = 1'b1;
                    out_eof_d      = 1'b0;
                    idx_d          = IDX_W'(1);
                    state_d        = ST_HDR;
                end else begin
                    out_valid_d = 1'b0;
                    out_sof_d   = 1'b0;
                    out_eof_d   = 1'b0;
                end
            end
            ST_HDR: begin
                if (load_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = hdr_word_s;
                    out_sof_d   = 1'b0;
                    out_eof_d   = 1'b0;
                    if (idx_q == LAST_HDR) begin
                        idx_d   = {IDX_W{1'b0}};
                        state_d = ST_REGS;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_REGS: begin
                if (load_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = reg_data_i;
                    out_sof_d   = 1'b0;
                    out_eof_d   = 1'b0;
                    if (idx_q == LAST_REG) begin
                        idx_d   = {IDX_W{1'b0}};
                        state_d = ST_MEM;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_REGS;
                end
            end
            ST_MEM: begin
                if (idx_q == MEM_DONE) begin
                    // Last word is held; the frame ends on its handshake.
                    if (out_ready_i) begin
                        out_valid_d = 1'b0;
                        out_sof_d   = 1'b0;
                        out_eof_d   = 1'b0;
                        idx_d       = {IDX_W{1'b0}};
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_MEM;
                    end
                end else if (load_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem_data_i;
                    out_sof_d   = 1'b0;
                    out_eof_d   = (idx_q == LAST_MEM);
                    idx_d       = idx_q + IDX_W'(1);
                end else begin
                    state_d = ST_MEM;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                idx_d       = {IDX_W{1'b0}};
                out_valid_d = 1'b0;
                out_sof_d   = 1'b0;
                out_eof_d   = 1'b0;
            end
        endcase
    end

    // State, index, output and shadow registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            idx_q          <= {IDX_W{1'b0}};
            out_valid_q    <= 1'b0;
            out_data_q     <= {DATA_W{1'b0}};
            out_sof_q      <= 1'b0;
            out_eof_q      <= 1'b0;
            shadow_cycle_q <= 32'd0;
            shadow_pc_q    <= 32'd0;
            shadow_stall_q <= 32'd0;
            shadow_flush_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_sof_q      <= out_sof_d;
            out_eof_q      <= out_eof_d;
            shadow_cycle_q <= shadow_cycle_d;
            shadow_pc_q    <= shadow_pc_d;
            shadow_stall_q <= shadow_stall_d;
            shadow_flush_q <= shadow_flush_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sof_o   = out_sof_q;
    assign out_eof_o   = out_eof_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
